// File: rtl/logical_eq_sequencer_pkg.sv
// ============================================================================
// Module   : logical_eq_pkg
// Purpose  : State encoding and width helper for the logical-EQ sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package logical_eq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_e;

   // A counter still needs one bit when only a single word is streamed.
   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

`default_nettype wire

// File: rtl/logical_eq_sequencer_if.sv
// ============================================================================
// Module   : logical_eq_sequencer_if
// Purpose  : Operand-beat input and result output handshakes of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface logical_eq_sequencer_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a_word;
   logic [N-1:0] b_word;
   logic         out_valid;
   logic         out_ready;
   logic         c;
   logic         a_nz;
   logic         b_nz;
   logic         busy;

   modport master (
      output in_valid, a_word, b_word, out_ready,
      input  in_ready, out_valid, c, a_nz, b_nz, busy
   );

   modport slave (
      input  in_valid, a_word, b_word, out_ready,
      output in_ready, out_valid, c, a_nz, b_nz, busy
   );
endinterface

`default_nettype wire

// File: rtl/logical_eq_sequencer_word_reduce.sv
// ============================================================================
// Module   : logical_eq_word_reduce
// Purpose  : OR-reduces one word of each operand to a "word nonzero" bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logical_eq_word_reduce #(
   parameter int N = 8
) (
   input  wire logic [N-1:0] a_word,
   input  wire logic [N-1:0] b_word,
   output logic              a_any,
   output logic              b_any
);
   assign a_any = |a_word;
   assign b_any = |b_word;
endmodule

`default_nettype wire

// File: rtl/logical_eq_sequencer.sv
// ============================================================================
// Module   : logical_eq_sequencer
// Purpose  : Streams WORDS beats per operand and reports logical equality.
//            Optional abort port enabled by LOGICAL_EQ_SEQUENCER_ABORT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logical_eq_sequencer
   import logical_eq_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  wire logic               clk,
   input  wire logic               rst,
`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
   input  wire logic               abort,
`endif
   logical_eq_sequencer_if.slave   bus
);
   localparam int            CW       = clog2_min1(WORDS);
   localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          acc_a_q, acc_a_d;
   logic          acc_b_q, acc_b_d;
   logic          c_q, c_d;
   logic          a_nz_q, a_nz_d;
   logic          b_nz_q, b_nz_d;

   logic a_any, b_any;
   logic fire_in;
   logic a_next, b_next;
   logic abort_req;

   logical_eq_word_reduce #(.N(N)) u_reduce (
      .a_word (bus.a_word),
      .b_word (bus.b_word),
      .a_any  (a_any),
      .b_any  (b_any)
   );

`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
   assign abort_req = abort & (state_q != IDLE);
`else
   assign abort_req = 1'b0;
`endif

   assign bus.in_ready  = (state_q != RESULT);
   assign bus.out_valid = (state_q == RESULT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.c         = c_q;
   assign bus.a_nz      = a_nz_q;
   assign bus.b_nz      = b_nz_q;

   assign fire_in = bus.in_valid & bus.in_ready;
   // Flags left over from the previous operand are ignored on its first beat.
   assign a_next  = ((state_q == IDLE) ? 1'b0 : acc_a_q) | a_any;
   assign b_next  = ((state_q == IDLE) ? 1'b0 : acc_b_q) | b_any;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      c_d     = c_q;
      a_nz_d  = a_nz_q;
      b_nz_d  = b_nz_q;
      if (abort_req) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_a_d = 1'b0;
         acc_b_d = 1'b0;
      end else if (fire_in) begin
         acc_a_d = a_next;
         acc_b_d = b_next;
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = RESULT;
            c_d     = ~(a_next ^ b_next);
            a_nz_d  = a_next;
            b_nz_d  = b_next;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ACCUM;
         end
      end else if ((state_q == RESULT) && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_a_q <= 1'b0;
         acc_b_q <= 1'b0;
         c_q     <= 1'b0;
         a_nz_q  <= 1'b0;
         b_nz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_a_q <= acc_a_d;
         acc_b_q <= acc_b_d;
         c_q     <= c_d;
         a_nz_q  <= a_nz_d;
         b_nz_q  <= b_nz_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_logical_eq_sequencer.sv
// ============================================================================
// Module   : tb_logical_eq_sequencer
// Purpose  : Directed checks of a WORDS=4 and a WORDS=1 sequencer instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_logical_eq_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   logical_eq_sequencer_if #(.N(8)) bus0 ();
   logical_eq_sequencer_if #(.N(8)) bus1 ();

`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
   logic abort0 = 1'b0;
   logic abort1 = 1'b0;
`endif

   logical_eq_sequencer #(.N(8), .WORDS(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
      .abort (abort0),
`endif
      .bus   (bus0)
   );

   logical_eq_sequencer #(.N(8), .WORDS(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
      .abort (abort1),
`endif
      .bus   (bus1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted beat on the WORDS=4 instance; checks out_valid is still low beforehand.
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input string tag);
      check({tag, "_pre_ready"}, bus0.in_ready, 1);
      check({tag, "_pre_ovalid"}, bus0.out_valid, 0);
      bus0.in_valid = 1'b1;
      bus0.a_word   = a;
      bus0.b_word   = b;
      tick();
      bus0.in_valid = 1'b0;
      bus0.a_word   = 8'h00;
      bus0.b_word   = 8'h00;
   endtask

   task automatic operand(input logic [31:0] a, input logic [31:0] b, input string tag);
      for (int i = 3; i >= 0; i--) beat(a[i*8 +: 8], b[i*8 +: 8], tag);
   endtask

   task automatic expect_result(input logic ec, input logic ea, input logic eb, input string tag);
      check({tag, "_ovalid"}, bus0.out_valid, 1);
      check({tag, "_in_ready"}, bus0.in_ready, 0);
      check({tag, "_c"}, bus0.c, ec);
      check({tag, "_a_nz"}, bus0.a_nz, ea);
      check({tag, "_b_nz"}, bus0.b_nz, eb);
   endtask

   task automatic handshake(input string tag);
      bus0.out_ready = 1'b1;
      tick();
      bus0.out_ready = 1'b0;
      check({tag, "_hs_ovalid"}, bus0.out_valid, 0);
      check({tag, "_hs_busy"}, bus0.busy, 0);
   endtask

   initial begin
      bus0.in_valid = 1'b0; bus0.a_word = 8'h00; bus0.b_word = 8'h00; bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.a_word = 8'h00; bus1.b_word = 8'h00; bus1.out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_in_ready", bus0.in_ready, 1);
      check("rst_ovalid", bus0.out_valid, 0);
      check("rst_c", bus0.c, 0);
      check("rst_a_nz", bus0.a_nz, 0);
      check("rst_b_nz", bus0.b_nz, 0);
      check("rst_busy", bus0.busy, 0);

      // All-zero operands: equal (both false)
      operand(32'h00000000, 32'h00000000, "zero");
      expect_result(1'b1, 1'b0, 1'b0, "zero");
      check("zero_busy", bus0.busy, 1);
      handshake("zero");
      check("zero_c_kept", bus0.c, 1);

      operand(32'h00001000, 32'h00000000, "a_only");
      expect_result(1'b0, 1'b1, 1'b0, "a_only");
      handshake("a_only");
      check("a_only_c_kept", bus0.c, 0);

      operand(32'h00000001, 32'h80000000, "both");
      expect_result(1'b1, 1'b1, 1'b1, "both");
      handshake("both");

      // Gapped beats, then a stalled consumer with a beat offered during RESULT
      for (int i = 0; i < 4; i++) begin
         beat(8'h00, (i == 1) ? 8'h05 : 8'h00, "gap");
         if (i < 3) begin
            repeat (3) begin
               tick();
               check("gap_busy", bus0.busy, 1);
               check("gap_ovalid", bus0.out_valid, 0);
            end
         end
      end
      expect_result(1'b0, 1'b0, 1'b1, "gap");
      bus0.in_valid = 1'b1; bus0.a_word = 8'hFF; bus0.b_word = 8'hFF;
      repeat (5) begin
         tick();
         expect_result(1'b0, 1'b0, 1'b1, "stall");
      end
      bus0.in_valid = 1'b0; bus0.a_word = 8'h00; bus0.b_word = 8'h00;
      handshake("stall");

      // Stale beats in RESULT must not have advanced the word counter
      operand(32'h00000000, 32'h00000000, "after_stall");
      expect_result(1'b1, 1'b0, 1'b0, "after_stall");
      handshake("after_stall");

      // Reset mid-operand drops the partial compare
      beat(8'hFF, 8'h00, "rst_mid");
      beat(8'hFF, 8'h00, "rst_mid");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", bus0.busy, 0);
      check("rst_mid_a_nz", bus0.a_nz, 0);
      repeat (3) begin
         tick();
         check("rst_mid_ovalid", bus0.out_valid, 0);
      end
      operand(32'h00000000, 32'h00000000, "post_rst");
      expect_result(1'b1, 1'b0, 1'b0, "post_rst");
      handshake("post_rst");

      // WORDS=1 instance: result the cycle after a single beat
      bus1.in_valid = 1'b1; bus1.a_word = 8'h01; bus1.b_word = 8'h00;
      tick();
      bus1.a_word = 8'h00;
      check("w1_ovalid", bus1.out_valid, 1);
      check("w1_c", bus1.c, 0);
      check("w1_a_nz", bus1.a_nz, 1);
      check("w1_in_ready", bus1.in_ready, 0);
      repeat (2) begin
         tick();
         check("w1_hold_ovalid", bus1.out_valid, 1);
         check("w1_hold_c", bus1.c, 0);
      end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      check("w1_hs_ovalid", bus1.out_valid, 0);
      check("w1_hs_in_ready", bus1.in_ready, 1);
      tick();
      bus1.in_valid = 1'b0;
      check("w1_next_ovalid", bus1.out_valid, 1);
      check("w1_next_c", bus1.c, 1);

`ifdef LOGICAL_EQ_SEQUENCER_ABORT_EN
      beat(8'hFF, 8'h00, "abort");
      beat(8'h00, 8'h00, "abort");
      beat(8'h00, 8'h00, "abort");
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      check("abort_busy", bus0.busy, 0);
      beat(8'h00, 8'h00, "abort_tail");
      check("abort_tail_ovalid", bus0.out_valid, 0);
      check("abort_tail_busy", bus0.busy, 1);
      bus0.in_valid = 1'b1;
      repeat (3) tick();
      bus0.in_valid = 1'b0;
      expect_result(1'b1, 1'b0, 1'b0, "abort_restart");
      abort0 = 1'b1;
      bus0.out_ready = 1'b1;
      tick();
      abort0 = 1'b0;
      bus0.out_ready = 1'b0;
      check("abort_hs_ovalid", bus0.out_valid, 0);
      check("abort_hs_busy", bus0.busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
